// File: rtl/cv32e40p_voter_err_tracker.sv
// cv32e40p_voter_err_tracker
// Per-replica error bookkeeping behind the 3-way majority voter.
// It keeps saturating error counters and sticky permanent-fault bits, and runs
// a NORMAL / DEGRADED / FAILED state machine with a one-cycle alarm pulse.
// Optional feature macro: CV32E40P_FT_ERR_DECAY_EN. When defined, a run of
// DECAY_PERIOD consecutive clean valid samples decrements every nonzero
// replica counter by one.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   NORMAL   | no replica declared faulty, no uncorrectable sample seen
//   DEGRADED | exactly one replica excluded (permanent fault)
//   FAILED   | two faulty replicas or an uncorrectable sample (sticky)
module cv32e40p_voter_err_tracker #(
    parameter int CNT_W        = 8,
    parameter int THRESHOLD    = 16,
    parameter int DECAY_PERIOD = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic                 err_detected_1_i,
    input  logic                 err_detected_2_i,
    input  logic                 err_detected_3_i,
    input  logic                 clear_i,
    output logic [3*CNT_W-1:0]   err_cnt_o,
    output logic [CNT_W-1:0]     uncorr_cnt_o,
    output logic [2:0]           perm_fault_o,
    output logic [1:0]           state_o,
    output logic                 alarm_o
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'b00,
        ST_DEGRADED = 2'b01,
        ST_FAILED   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LP_THR = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] LP_MAX = '1;
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    // Reject parameter values that would make the threshold or decay period meaningless.
    if (DECAY_PERIOD < 2 || THRESHOLD < 1 || THRESHOLD > (2**CNT_W) - 1) begin : g_bad_param
        $error("cv32e40p_voter_err_tracker: illegal THRESHOLD/DECAY_PERIOD");
    end

    logic [CNT_W-1:0] r_cnt [3];
    logic [CNT_W-1:0] r_uncorr;
    logic [2:0]       r_perm;
    state_t           r_state;
    logic             r_alarm;

    logic [2:0]       w_flags;
    logic             w_multi;
    logic             w_single;
    logic             w_uncorr;
    logic             w_clean;
    logic             w_decay;
    logic [CNT_W-1:0] w_cnt_nxt [3];
    logic [2:0]       w_new_perm;
    logic [2:0]       w_perm_nxt;
    logic             w_two_perm;
    state_t           w_state_nxt;

`ifdef CV32E40P_FT_ERR_DECAY_EN
    localparam int DEC_W = $clog2(DECAY_PERIOD);
    localparam logic [DEC_W-1:0] LP_DEC_LAST = DEC_W'(DECAY_PERIOD - 1);

    logic [DEC_W-1:0] r_clean;

    // Count consecutive clean valid samples; any flagged valid sample restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clean <= '0;
        end else if (clear_i) begin
            r_clean <= '0;
        end else if (valid_i) begin
            if (!w_clean || w_decay) r_clean <= '0;
            else                     r_clean <= r_clean + DEC_W'(1);
        end
    end

    assign w_decay = w_clean && (r_clean == LP_DEC_LAST);
`else
    assign w_decay = 1'b0;
`endif

    // Classify the sample, compute next counters, new faults and next state.
    always_comb begin
        w_flags    = {err_detected_3_i, err_detected_2_i, err_detected_1_i};
        w_multi    = (w_flags[0] & w_flags[1]) | (w_flags[0] & w_flags[2]) |
                     (w_flags[1] & w_flags[2]);
        w_single   = valid_i & (|w_flags) & ~w_multi;
        w_uncorr   = valid_i & w_multi;
        w_clean    = valid_i & ~(|w_flags);
        w_new_perm = 3'b000;
        for (int k = 0; k < 3; k++) begin
            w_cnt_nxt[k] = r_cnt[k];
            if (w_single && w_flags[k]) begin
                if (r_cnt[k] != LP_MAX) w_cnt_nxt[k] = r_cnt[k] + LP_ONE;
                // Only a not-yet-faulty replica can cause a new transition.
                w_new_perm[k] = (w_cnt_nxt[k] >= LP_THR) & ~r_perm[k];
            end else if (w_decay && r_cnt[k] != '0) begin
                w_cnt_nxt[k] = r_cnt[k] - LP_ONE;
            end
        end
        w_perm_nxt = r_perm | w_new_perm;
        w_two_perm = (w_perm_nxt[0] & w_perm_nxt[1]) | (w_perm_nxt[0] & w_perm_nxt[2]) |
                     (w_perm_nxt[1] & w_perm_nxt[2]);
        w_state_nxt = r_state;
        case (r_state)
            ST_NORMAL: begin
                if (w_uncorr || w_two_perm) w_state_nxt = ST_FAILED;
                else if (|w_new_perm)       w_state_nxt = ST_DEGRADED;
            end
            ST_DEGRADED: begin
                if (w_uncorr || (|w_new_perm)) w_state_nxt = ST_FAILED;
            end
            default: w_state_nxt = ST_FAILED;
        endcase
    end

    // Register counters, fault mask, state and the transition alarm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) r_cnt[k] <= '0;
            r_uncorr <= '0;
            r_perm   <= 3'b000;
            r_state  <= ST_NORMAL;
            r_alarm  <= 1'b0;
        end else if (clear_i) begin
            for (int k = 0; k < 3; k++) r_cnt[k] <= '0;
            r_uncorr <= '0;
            r_perm   <= 3'b000;
            r_state  <= ST_NORMAL;
            r_alarm  <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) r_cnt[k] <= w_cnt_nxt[k];
            if (w_uncorr && r_uncorr != LP_MAX) r_uncorr <= r_uncorr + LP_ONE;
            r_perm  <= w_perm_nxt;
            r_state <= w_state_nxt;
            r_alarm <= (w_state_nxt != r_state);
        end
    end

    assign err_cnt_o    = {r_cnt[2], r_cnt[1], r_cnt[0]};
    assign uncorr_cnt_o = r_uncorr;
    assign perm_fault_o = r_perm;
    assign state_o      = r_state;
    assign alarm_o      = r_alarm;

endmodule
